hvmux_chain_ctl: RTL and testbench

// Next-generation MAX14866 HV mux controller: drives CHAIN_N daisy-chained muxes
// (SWITCH_N switches each) over one SPI-like link. Adds a valid/ready input

---
 rtl/hvmux_chain_ctl.sv | 192 +++++++++++++++++++
 tb/tb_hvmux_chain_ctl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hvmux_chain_ctl.sv
`default_nettype none
// ============================================================================
// Module  : hvmux_chain_ctl
// Brief   : Serial controller for a daisy chain of MAX14866 HV muxes. It takes
//           words over a valid/ready handshake, has a runtime SPI divider and a
//           CLR pulse, and checks the chain readback against the last word written.
// Revision: 1.0  initial release
// ============================================================================
module hvmux_chain_ctl #(
  parameter int SWITCH_N = 16,
  parameter int CHAIN_N  = 2,
  parameter int DIV_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SWITCH_N*CHAIN_N-1:0] din,
  input  logic                        din_valid,
  output logic                        din_ready,
  input  logic [DIV_W-1:0]            clk_div,
  input  logic                        clr_req,
  output logic                        spi_le_n,
  output logic                        spi_clk,
  output logic                        spi_din,
  output logic                        spi_clr,
  input  logic                        spi_dout,
  output logic [SWITCH_N*CHAIN_N-1:0] rdback,
  output logic                        rdback_valid,
  output logic                        rdback_err,
  output logic                        busy
);

  localparam int TOTAL = SWITCH_N * CHAIN_N;
  localparam int IDX_W = $clog2(TOTAL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_LATCH = 3'd2,
    S_GAP   = 3'd3,
    S_CLR   = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div, div_nxt;
  logic [DIV_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [TOTAL-1:0]   word, word_nxt;
  logic [TOTAL-1:0]   rd_sh, rd_sh_nxt;
  logic [TOTAL-1:0]   shadow, shadow_nxt;
  logic               shadow_valid, shadow_valid_nxt;
  logic               le_n_nxt, sclk_nxt, sdin_nxt, sclr_nxt, busy_nxt;
  logic [TOTAL-1:0]   rdback_nxt;
  logic               rv_nxt, err_nxt;
  logic               phase_done;
  logic [IDX_W-1:0]   idx_dec;

  assign din_ready  = rst_n && (state == S_IDLE);
  assign phase_done = (cnt == div);
  assign idx_dec    = idx - 1'b1;

  always_comb begin
    state_nxt        = state;
    div_nxt          = div;
    cnt_nxt          = cnt;
    idx_nxt          = idx;
    word_nxt         = word;
    rd_sh_nxt        = rd_sh;
    shadow_nxt       = shadow;
    shadow_valid_nxt = shadow_valid;
    le_n_nxt         = spi_le_n;
    sclk_nxt         = spi_clk;
    sdin_nxt         = spi_din;
    sclr_nxt         = spi_clr;
    busy_nxt         = busy;
    rdback_nxt       = rdback;
    rv_nxt           = 1'b0;
    err_nxt          = rdback_err;
    case (state)
      S_IDLE: begin
        // CLR wins over a word offered in the same cycle; the word stays pending.
        if (clr_req) begin
          state_nxt = S_CLR;
          div_nxt   = clk_div;
          cnt_nxt   = '0;
          sclr_nxt  = 1'b1;
          busy_nxt  = 1'b1;
        end else if (din_valid) begin
          state_nxt = S_SHIFT;
          div_nxt   = clk_div;
          cnt_nxt   = '0;
          idx_nxt   = IDX_W'(TOTAL - 1);
          word_nxt  = din;
          sdin_nxt  = din[TOTAL-1];
          sclk_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      S_SHIFT: begin
        if (!phase_done) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          cnt_nxt = '0;
          if (!spi_clk) begin
            // DOUT is taken just before the chain sees this rising edge.
            sclk_nxt  = 1'b1;
            rd_sh_nxt = {rd_sh[TOTAL-2:0], spi_dout};
          end else if (idx == '0) begin
            sclk_nxt  = 1'b0;
            le_n_nxt  = 1'b0;
            state_nxt = S_LATCH;
          end else begin
            sclk_nxt = 1'b0;
            idx_nxt  = idx_dec;
            sdin_nxt = word[idx_dec];
          end
        end
      end
      S_LATCH: begin
        if (!phase_done) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          cnt_nxt   = '0;
          le_n_nxt  = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (!phase_done) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          state_nxt        = S_IDLE;
          busy_nxt         = 1'b0;
          rdback_nxt       = rd_sh;
          rv_nxt           = 1'b1;
          err_nxt          = shadow_valid && (rd_sh != shadow);
          shadow_nxt       = word;
          shadow_valid_nxt = 1'b1;
        end
      end
      S_CLR: begin
        if (!phase_done) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          state_nxt = S_IDLE;
          sclr_nxt  = 1'b0;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      div          <= '0;
      cnt          <= '0;
      idx          <= '0;
      word         <= '0;
      rd_sh        <= '0;
      shadow       <= '0;
      shadow_valid <= 1'b0;
      spi_le_n     <= 1'b1;
      spi_clk      <= 1'b0;
      spi_din      <= 1'b0;
      spi_clr      <= 1'b0;
      busy         <= 1'b0;
      rdback       <= '0;
      rdback_valid <= 1'b0;
      rdback_err   <= 1'b0;
    end else begin
      state        <= state_nxt;
      div          <= div_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      word         <= word_nxt;
      rd_sh        <= rd_sh_nxt;
      shadow       <= shadow_nxt;
      shadow_valid <= shadow_valid_nxt;
      spi_le_n     <= le_n_nxt;
      spi_clk      <= sclk_nxt;
      spi_din      <= sdin_nxt;
      spi_clr      <= sclr_nxt;
      busy         <= busy_nxt;
      rdback       <= rdback_nxt;
      rdback_valid <= rv_nxt;
      rdback_err   <= err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hvmux_chain_ctl.sv
`default_nettype none
// Scoreboard bench for hvmux_chain_ctl: directed writes, CLR, busy-time pulses and
// mid-transfer reset, with a 32-bit delay-line model of the mux chain on DOUT.
module tb_hvmux_chain_ctl;

  localparam int K_XFER  = 0;
  localparam int K_CLR   = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    int          kind;
    int          h;
    logic [31:0] word;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sbq[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic [7:0]  clk_div = '0;
  logic        clr_req = 1'b0;
  logic        din_ready, spi_le_n, spi_clk, spi_din, spi_clr, spi_dout;
  logic [31:0] rdback;
  logic        rdback_valid, rdback_err, busy;

  int n_checks = 0;
  int n_pass   = 0;

  hvmux_chain_ctl #(.SWITCH_N(16), .CHAIN_N(2), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .clk_div(clk_div), .clr_req(clr_req), .spi_le_n(spi_le_n), .spi_clk(spi_clk),
    .spi_din(spi_din), .spi_clr(spi_clr), .spi_dout(spi_dout), .rdback(rdback),
    .rdback_valid(rdback_valid), .rdback_err(rdback_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Mux chain model: shifts on spi_clk rise, DOUT is the last device MSB.
  logic [31:0] chain = '0;
  int          sh_cnt = 0;
  int          flip_at = -1;
  always @(posedge spi_clk) begin
    chain  <= {chain[30:0], spi_din};
    sh_cnt <= sh_cnt + 1;
  end
  assign spi_dout = chain[31] ^ (sh_cnt == flip_at);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  bit          mon_en = 0;
  int          cyc = 0, busy_len = 0, rises = 0, le_len = 0, clr_len = 0, din_bad = 0;
  int          gap_min = 0, gap_max = 0, last_rise = 0, rv_stray = 0, gap = 0;
  logic [31:0] cap = '0;
  logic        prev_busy = 1'b0, prev_clk = 1'b0, prev_din = 1'b0;
  exp_t        me;

  task automatic clear_meas();
    busy_len = 0; rises = 0; le_len = 0; clr_len = 0; din_bad = 0;
    gap_min = 1 << 30; gap_max = 0; cap = '0;
  endtask

  initial begin
    clear_meas();
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_en) begin
        clear_meas();
        prev_busy = 1'b0; prev_clk = 1'b0; prev_din = 1'b0;
      end else begin
        if (busy === 1'b1) busy_len++;
        if (spi_clk === 1'b1 && prev_clk === 1'b0) begin
          if (rises > 0) begin
            gap = cyc - last_rise;
            if (gap < gap_min) gap_min = gap;
            if (gap > gap_max) gap_max = gap;
          end
          last_rise = cyc;
          rises++;
          cap = {cap[30:0], spi_din};
        end
        if (spi_le_n === 1'b0) le_len++;
        if (spi_clr === 1'b1) clr_len++;
        if (busy && prev_busy && (spi_din !== prev_din) && !(prev_clk && !spi_clk)) din_bad++;
        if (prev_busy && !busy) begin
          if (sbq.size() == 0) begin
            chk("unexpected_episode", 32'(rises), 32'hFFFF_FFFF);
          end else begin
            me = sbq.pop_front();
            if (me.kind == K_XFER) begin
              chk("xfer_busy_len", 32'(busy_len), 32'(2 * me.h * 33));
              chk("xfer_rises", 32'(rises), 32'd32);
              chk("xfer_gap_min", 32'(gap_min), 32'(2 * me.h));
              chk("xfer_gap_max", 32'(gap_max), 32'(2 * me.h));
              chk("xfer_le_len", 32'(le_len), 32'(me.h));
              chk("xfer_clr_len", 32'(clr_len), 32'd0);
              chk("xfer_din_bits", cap, me.word);
              chk("xfer_din_stable", 32'(din_bad), 32'd0);
              chk("xfer_rdback_valid", 32'(rdback_valid), 32'd1);
              chk("xfer_rdback", rdback, me.rd);
              chk("xfer_rdback_err", 32'(rdback_err), 32'(me.err));
            end else if (me.kind == K_CLR) begin
              chk("clr_busy_len", 32'(busy_len), 32'(me.h));
              chk("clr_pulse_len", 32'(clr_len), 32'(me.h));
              chk("clr_rises", 32'(rises), 32'd0);
              chk("clr_le_len", 32'(le_len), 32'd0);
              chk("clr_rdback_valid", 32'(rdback_valid), 32'd0);
            end else begin
              chk("abort_rises", 32'(rises), 32'd10);
              chk("abort_le_len", 32'(le_len), 32'd0);
              chk("abort_outputs",
                  32'({spi_le_n, spi_clk, spi_din, spi_clr, busy, rdback_valid, rdback_err, din_ready}),
                  32'h80);
              chk("abort_rdback", rdback, 32'h0);
            end
          end
          clear_meas();
        end else if (rdback_valid === 1'b1) begin
          rv_stray++;
        end
        prev_busy = busy; prev_clk = spi_clk; prev_din = spi_din;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] sh = '0;
  bit          sh_valid = 0;

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (din_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_exp(input int kind, input logic [31:0] word, input int div,
                          input logic [31:0] mask);
    exp_t e;
    e.kind = kind; e.h = div + 1; e.word = word; e.rd = chain ^ mask;
    e.err  = sh_valid && (e.rd != sh);
    if (kind == K_XFER) begin sh = word; sh_valid = 1; end
    else if (kind == K_ABORT) sh_valid = 0;
    sbq.push_back(e);
  endtask

  task automatic write(input logic [31:0] word, input int div, input logic [31:0] mask,
                       input int kind);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    push_exp(kind, word, div, mask);
    din = word; clk_div = 8'(div); din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    logic p;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({spi_le_n, spi_clk, spi_din, spi_clr, busy, rdback_valid, rdback_err, din_ready}), 32'h80);
    chk("reset_rdback", rdback, 32'h0);
    rst_n = 1'b1; mon_en = 1;
    #1;
    chk("ready_after_reset", 32'(din_ready), 32'd1);
    @(negedge clk);

    // Basic write, then loopback readback, then a corrupted DOUT bit.
    write(32'hA5A50F0F, 3, 32'h0, K_XFER);
    write(32'h12345678, 3, 32'h0, K_XFER);
    wait_ready(ok);
    flip_at = sh_cnt + 24;
    write(32'hDEADBEEF, 3, 32'h80, K_XFER);
    write(32'h5A5AC3C3, 0, 32'h0, K_XFER);

    // CLR and a word offered together: CLR first, word accepted afterwards.
    wait_ready(ok);
    push_exp(K_CLR, 32'h0, 5, 32'h0);
    push_exp(K_XFER, 32'h3C3C9696, 1, 32'h0);
    din = 32'h3C3C9696; din_valid = 1'b1; clr_req = 1'b1; clk_div = 8'd5;
    @(negedge clk);
    clr_req = 1'b0; clk_div = 8'd1;
    chk("clr_ready_drop", 32'(din_ready), 32'd0);
    chk("clr_started", 32'(spi_clr), 32'd1);
    wait_ready(ok);
    @(negedge clk);
    din_valid = 1'b0;

    // Requests while busy must be ignored.
    write(32'hC0FFEE11, 2, 32'h0, K_XFER);
    repeat (20) @(negedge clk);
    din = 32'hFFFFFFFF; din_valid = 1'b1; clr_req = 1'b1; clk_div = 8'd7;
    chk("busy_ready_low", 32'(din_ready), 32'd0);
    @(negedge clk);
    din_valid = 1'b0; clr_req = 1'b0;

    // Reset after the 10th rising edge aborts the transfer.
    wait_ready(ok);
    push_exp(K_ABORT, 32'h89ABCDEF, 1, 32'h0);
    din = 32'h89ABCDEF; clk_div = 8'd1; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    n = 0; p = spi_clk;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(negedge clk);
      if (spi_clk && !p) n++;
      p = spi_clk;
    end
    if (n < 10) chk("abort_edge_timeout", 32'(n), 32'd10);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    write(32'h600DF00D, 1, 32'h0, K_XFER);
    write(32'h00000000, 0, 32'h0, K_XFER);

    for (int i = 0; i < 4000; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    chk("scoreboard_drain", 32'(sbq.size()), 32'd0);
    repeat (4) @(negedge clk);
    chk("rdback_valid_stray", 32'(rv_stray), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
